// File: rtl/dma_bus_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA memory-bus arbiter.
package dma_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_GRANT   = 3'd3,
    ST_RELEASE = 3'd4
  } arb_state_e;

  localparam int WD_CYCLES_DEFAULT = 64;
  localparam int WORD_SIZE         = 64;
  localparam int WD_CNT_W          = 10;

  // States in which a transfer is being negotiated or is in flight.
  function automatic logic is_active(input arb_state_e s);
    return (s == ST_REQ) || (s == ST_DRAIN) || (s == ST_GRANT);
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// CPU / DMA engine handshake bundle; slave is the arbiter side, master the CPU+engine side.
interface dma_bus_arbiter_if;
  logic cpu_dma_start;
  logic cpu_bus_busy;
  logic BR;
  logic dma_interrupt;
  logic cmd;
  logic BG;
  logic cpu_stall;
  logic dma_done;
  logic dma_error;
  logic busy;

  modport slave (
    input  cpu_dma_start, cpu_bus_busy, BR, dma_interrupt,
    output cmd, BG, cpu_stall, dma_done, dma_error, busy
  );

  modport master (
    output cpu_dma_start, cpu_bus_busy, BR, dma_interrupt,
    input  cmd, BG, cpu_stall, dma_done, dma_error, busy
  );
endinterface

// File: rtl/dma_bus_arbiter_watchdog.sv
// Transfer watchdog: counts active cycles since request acceptance and flags expiry.
module dma_watchdog
  import dma_bus_arbiter_pkg::*;
#(
  parameter int WD_CYCLES = WD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [WD_CNT_W-1:0] LIMIT = WD_CNT_W'(WD_CYCLES - 1);

  logic [WD_CNT_W-1:0] count_r;

  // Active-cycle counter, restarted whenever a new request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (run) begin
      count_r <= count_r + 10'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Fires on the cycle whose edge would make the count reach WD_CYCLES.
  assign expired = run && (count_r == LIMIT);

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shared-bus arbiter between CPU and DMA engine; optional watchdog under DMA_WATCHDOG_EN.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int WD_CYCLES = WD_CYCLES_DEFAULT
) (
  input logic              CLK,
  input logic              reset_n,
  dma_bus_arbiter_if.slave bus
);

  arb_state_e state_r, next_s;
  logic       pending_r, pending_n;
  logic       expired_s;
  logic       cmd_r, bg_r, stall_r, done_r, busy_r;

  // Next-state and one-deep pending-request bookkeeping.
  always_comb begin
    next_s    = state_r;
    pending_n = pending_r;
    if ((state_r != ST_IDLE) && bus.cpu_dma_start) begin
      pending_n = 1'b1;
    end else begin
      pending_n = pending_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (bus.cpu_dma_start || pending_r) begin
          next_s    = ST_REQ;
          pending_n = 1'b0;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (expired_s)   next_s = ST_RELEASE;
        else if (bus.BR) next_s = ST_DRAIN;
        else             next_s = ST_REQ;
      end
      ST_DRAIN: begin
        if (expired_s)              next_s = ST_RELEASE;
        else if (!bus.cpu_bus_busy) next_s = ST_GRANT;
        else                        next_s = ST_DRAIN;
      end
      ST_GRANT: begin
        if (bus.dma_interrupt || expired_s) next_s = ST_RELEASE;
        else                                next_s = ST_GRANT;
      end
      ST_RELEASE: begin
        if (!bus.BR && !bus.dma_interrupt) next_s = ST_IDLE;
        else                               next_s = ST_RELEASE;
      end
      default: begin
        next_s    = ST_IDLE;
        pending_n = 1'b0;
      end
    endcase
  end

  // State register; outputs are decoded from the next state so they change with it.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      pending_r <= 1'b0;
      cmd_r     <= 1'b0;
      bg_r      <= 1'b0;
      stall_r   <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= next_s;
      pending_r <= pending_n;
      cmd_r     <= is_active(next_s);
      bg_r      <= (next_s == ST_GRANT);
      stall_r   <= (next_s == ST_DRAIN) || (next_s == ST_GRANT) || (next_s == ST_RELEASE);
      done_r    <= (state_r == ST_RELEASE) && (next_s == ST_IDLE);
      busy_r    <= (next_s != ST_IDLE);
    end
  end

  assign bus.cmd       = cmd_r;
  assign bus.BG        = bg_r;
  assign bus.cpu_stall = stall_r;
  assign bus.dma_done  = done_r;
  assign bus.busy      = busy_r;

`ifdef DMA_WATCHDOG_EN
  logic accept_s, run_s, error_r;

  assign accept_s = (state_r == ST_IDLE) && (next_s == ST_REQ);
  assign run_s    = is_active(state_r);

  dma_watchdog #(.WD_CYCLES(WD_CYCLES)) u_wd (
    .clk     (CLK),
    .rst_n   (reset_n),
    .clear   (accept_s),
    .run     (run_s),
    .expired (expired_s)
  );

  // Sticky error: set by a watchdog abort, cleared by the next accepted request.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      error_r <= 1'b0;
    end else if (expired_s) begin
      error_r <= 1'b1;
    end else if (accept_s) begin
      error_r <= 1'b0;
    end else begin
      error_r <= error_r;
    end
  end

  assign bus.dma_error = error_r;
`else
  assign expired_s     = 1'b0;
  assign bus.dma_error = 1'b0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Randomized transfer-level bench: planned timelines give expected outputs per cycle.
module tb_dma_bus_arbiter;

  localparam int WD   = 16;
  localparam int MAXE = 2048;
`ifdef DMA_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  dma_bus_arbiter_if bus();

  dma_bus_arbiter #(.WD_CYCLES(WD)) dut (
    .CLK     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int         edge_n;
    logic [5:0] v;
  } exp_t;

  exp_t       sbq[$];
  bit         s_start[MAXE];
  bit         s_br[MAXE];
  bit         s_busy[MAXE];
  bit         s_irq[MAXE];
  logic [5:0] e_out[MAXE];   // {cmd, BG, cpu_stall, dma_done, dma_error, busy}
  int         total = 0;
  int         bad = 0;
  int         err_from = -1;

  function automatic logic [5:0] outs();
    return {bus.cmd, bus.BG, bus.cpu_stall, bus.dma_done, bus.dma_error, bus.busy};
  endfunction

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("out_vec@%0d", e.edge_n), outs(), e.v);
    end
  end

  task automatic fill_idle(input int from, input int to);
    for (int n = from; n <= to; n++) begin
      s_start[n] = 1'b0;
      s_br[n]    = 1'($urandom_range(0, 1));
      s_busy[n]  = 1'($urandom_range(0, 1));
      s_irq[n]   = 1'($urandom_range(0, 1));
      e_out[n]   = 6'b0;
    end
  endtask

  task automatic close_err(input int to);
    if (err_from >= 0) begin
      for (int n = err_from; n <= to; n++) e_out[n][1] = 1'b1;
      err_from = -1;
    end
  endtask

  // One transfer starting at edge s (REQ after s): BR at bb, grant at g, end at kk, exit at x.
  task automatic plan_transfer(input int s, input bit own, input int nextra, input bit wd,
                               input bit force_k, output int x, output int g);
    int d, b, i, r, h, bb, kk, mx, p1, p2;
    close_err(s - 1);
    d  = int'($urandom_range(0, 2));
    b  = int'($urandom_range(0, 4));
    i  = int'($urandom_range(1, 7));
    r  = int'($urandom_range(0, 3));
    h  = wd ? 0 : int'($urandom_range(1, 3));
    bb = s + 1 + d;
    g  = bb + 1 + b;
    kk = wd ? s + WD : g + i;
    mx = (h > r) ? h : r;
    if (mx < 1) mx = 1;
    x = kk + mx;
    if (own) s_start[s] = 1'b1;
    for (int n = s + 1; n < bb; n++) s_br[n] = 1'b0;
    s_br[bb] = 1'b1;
    for (int n = kk; n < kk + r; n++) s_br[n] = 1'b1;
    for (int n = kk + r; n <= x; n++) s_br[n] = 1'b0;
    for (int n = bb + 1; n <= bb + b; n++) s_busy[n] = 1'b1;
    s_busy[g] = 1'b0;
    for (int n = g + 1; n < kk; n++) s_irq[n] = 1'b0;
    for (int n = kk; n < kk + h; n++) s_irq[n] = 1'b1;
    for (int n = kk + h; n <= x; n++) s_irq[n] = 1'b0;
    for (int n = s; n <= x; n++) begin
      e_out[n][5] = (n < kk);
      e_out[n][4] = (n >= g) && (n < kk);
      e_out[n][3] = (n >= bb) && (n < x);
      e_out[n][2] = (n == x);
      e_out[n][0] = (n < x);
    end
    if (wd) err_from = kk;
    if (nextra >= 1) begin
      p1 = force_k ? kk : int'($urandom_range(s + 1, x));
      s_start[p1] = 1'b1;
      if (nextra >= 2) begin
        p2 = (p1 == x) ? s + 1 : p1 + 1;
        s_start[p2] = 1'b1;
      end
    end
  endtask

  task automatic plan_phase(input int base, input int ntr, output int last);
    int s, x, g, ne;
    bit own;
    fill_idle(base, MAXE - 1);
    s   = base + int'($urandom_range(3, 5));
    own = 1'b1;
    x   = s;
    for (int t = 0; t < ntr; t++) begin
      ne = (t == ntr - 1) ? 0 : int'($urandom_range(0, 2));
      if (t == 1) ne = 1;
      plan_transfer(s, own, ne, WD_ON && (t == 3), (t == 1), x, g);
      if (ne > 0) begin
        s   = x + 1;
        own = 1'b0;
      end else begin
        s   = x + 1 + int'($urandom_range(0, 3));
        own = 1'b1;
      end
    end
    last = x + 4;
    close_err(last);
  endtask

  task automatic drive(input int from, input int to);
    for (int n = from; n <= to; n++) begin
      bus.cpu_dma_start = s_start[n];
      bus.BR            = s_br[n];
      bus.cpu_bus_busy  = s_busy[n];
      bus.dma_interrupt = s_irq[n];
      @(posedge clk);
      sbq.push_back('{edge_n: n, v: e_out[n]});
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_dma_start = 1'b0;
    bus.BR            = 1'b0;
    bus.cpu_bus_busy  = 1'b0;
    bus.dma_interrupt = 1'b0;
  endtask

  initial begin
    int e1, e2, x, g, base;
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", outs(), 6'b0);
    @(negedge clk);
    reset_n = 1'b1;

    plan_phase(0, 24, e1);
    drive(0, e1);
    @(negedge clk);
    #1;

    // Reset while granted, with a pending start queued.
    base = e1 + 1;
    fill_idle(base, MAXE - 1);
    plan_transfer(base + 3, 1'b1, 0, 1'b0, 1'b0, x, g);
    s_start[g] = 1'b1;
    drive(base, g);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", outs(), 6'b0);
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    plan_phase(g + 5, 8, e2);
    drive(g + 5, e2);
    @(negedge clk);
    #1;

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain left=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Sequencer and arbiter for the shared 64-bit memory bus between the CPU and the DMA engine. It turns a CPU "start DMA" request into the engine's `cmd`. It answers the engine's bus request (`BR`) with a bus grant (`BG`) only after the CPU has drained any in-flight memory access, and stalls the CPU while the engine owns the bus. On engine completion it withdraws the grant and pulses a completion event back to the CPU. It sits at top level, between the CPU, the DMA engine and the memory.

## Interface
Parameters:
- `WD_CYCLES`, default 64: watchdog limit in cycles. Used only when `DMA_WATCHDOG_EN` is defined. Legal range 8..1023.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_dma_start`  in  1  one-cycle pulse from the CPU requesting a transfer.
- `cpu_bus_busy`  in  1  CPU has a memory access in flight; the bus cannot be handed over.
- `BR`  in  1  bus request from the DMA engine.
- `dma_interrupt`  in  1  completion signal from the DMA engine.
- `cmd`  out  1  DMA command to the engine.
- `BG`  out  1  bus grant to the engine; the CPU tri-states its memory drivers while this is high.
- `cpu_stall`  out  1  CPU must not issue a new memory access.
- `dma_done`  out  1  one-cycle completion pulse to the CPU.
- `dma_error`  out  1  sticky watchdog error flag.
- `busy`  out  1  arbiter is not in IDLE.

## Operation
All outputs are registered. Reset value of every output is 0, state is IDLE, and `pending` is 0.

State machine:
- IDLE: all outputs 0.
  - `cpu_dma_start` or `pending` set → REQ, with `pending` cleared.
- REQ: `cmd`=1.
  - `BR`=1 → DRAIN.
- DRAIN: `cmd`=1, `cpu_stall`=1.
  - `cpu_bus_busy`=0 → GRANT.
  - Minimum dwell is 1 cycle, so the stall is visible before `BG` rises.
- GRANT: `cmd`=1, `cpu_stall`=1, `BG`=1.
  - `dma_interrupt`=1 → RELEASE.
- RELEASE: `cmd`=0, `BG`=0, `cpu_stall`=1.
  - When `BR`=0 and `dma_interrupt`=0 → IDLE.
  - `dma_done` pulses on the transition cycle.
  - `cmd` is dropped here so the engine does not re-request after clearing its interrupt.

Boundary conditions:
- `cpu_dma_start` outside IDLE sets the one-deep `pending` bit. Further starts while `pending` is set are dropped.
- A pending request is serviced with 1 idle cycle after `dma_done`.
- In IDLE, a `BR` arriving with no `cmd` is ignored; no grant is issued.
- If `BR` falls during DRAIN or GRANT without `dma_interrupt`, the arbiter stays in its state. Only the interrupt, or the watchdog when enabled, ends the grant.
- If `cpu_dma_start` and `dma_interrupt` arrive in the same cycle while in GRANT, `pending` is set and the arbiter still moves to RELEASE.
- Reset asserted mid-transfer drops `BG`, `cmd` and `cpu_stall` immediately (asynchronously) and clears `pending`.

## Timing
- `cpu_dma_start` at edge N → `cmd`=1 after edge N.
- `BR` sampled high at edge M → `cpu_stall`=1 after M; `BG`=1 after M+1 at the earliest.
- `BG` rises on the edge after `cpu_bus_busy` is sampled low in DRAIN.
- `dma_interrupt` sampled at edge K → `BG`=0 and `cmd`=0 after K.
- `dma_done` is high for exactly one cycle after the edge where RELEASE exits.
- `busy` equals (state != IDLE) and is registered alongside the state.

## Configuration
- Macro `DMA_WATCHDOG_EN`.
- Defined:
  - A 10-bit counter runs in REQ, DRAIN and GRANT. It resets on entry to REQ.
  - When the count reaches `WD_CYCLES`: go to RELEASE and set `dma_error`=1.
  - `dma_done` still pulses on RELEASE exit.
  - `dma_error` clears when the next request is accepted in IDLE.
- Undefined: no counter; `dma_error` is tied to 0.

## Structure
- Shared package/header holds:
  - the state encoding constants (IDLE=0, REQ=1, DRAIN=2, GRANT=3, RELEASE=4; 3 bits);
  - the `WD_CYCLES` default;
  - `WORD_SIZE`.
- One sub-module: `dma_watchdog`, containing the counter and compare, with a single `expired` output. It is instantiated only under `DMA_WATCHDOG_EN`.

## Test plan
- Basic transfer:
  - Stimulus: start pulse; `BR` 1 cycle after `cmd`; `cpu_bus_busy`=0; `dma_interrupt` 15 cycles after `BG`.
  - Required: `cmd`, then `cpu_stall`, then `BG` one cycle later. `BG` and `cmd` drop the cycle after the interrupt. `dma_done` is a single pulse once `BR` and the interrupt are both low.
- Drain:
  - Stimulus: hold `cpu_bus_busy`=1 for 3 cycles after `BR`.
  - Required: `cpu_stall`=1 throughout and `BG`=0. `BG` rises exactly 1 cycle after `cpu_bus_busy` falls.
- Pending:
  - Stimulus: second start pulse during GRANT.
  - Required: after `dma_done`, 1 idle cycle, then `cmd` reasserts. A third start pulse during that transfer is dropped.
- Reset mid-GRANT:
  - Stimulus: assert `reset_n`=0 between clock edges.
  - Required: `BG`, `cmd` and `cpu_stall` are 0 before the next edge; state is IDLE after release.
- Stray request:
  - Stimulus: `BR`=1 while in IDLE.
  - Required: `BG` stays 0 and `cpu_stall` stays 0.
- Watchdog (`DMA_WATCHDOG_EN`, `WD_CYCLES`=16):
  - Stimulus: no `dma_interrupt`.
  - Required: `BG` drops 16 cycles after REQ entry; `dma_error`=1; `dma_done` pulses. The next start clears `dma_error`.
